// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 line responder.
// Line type, responder states and address-to-index mapping.
package l2_pkg;

  localparam int LINE_BITS = 512;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT
  } responder_state_t;

  // Drop the byte offset, keep idx_bits of line index.
  function automatic logic [63:0] line_index(
    input logic [63:0] addr,
    input int unsigned off_bits,
    input int unsigned idx_bits
  );
    logic [63:0] m;
    m = (64'd1 << idx_bits) - 64'd1;
    return (addr >> off_bits) & m;
  endfunction

endpackage

// File: rtl/l2_line_store.sv
// Single-port line store, one access per cycle.
// Read data is registered and held until the next read.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int LINE_COUNT = 1024,
  parameter int INDEX_SIZE = $clog2(LINE_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [INDEX_SIZE-1:0] i_index,
  input  line_t                 i_wdata,
  output line_t                 o_rdata
);

  line_t r_mem [LINE_COUNT];
  line_t r_rdata;

  // Line array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_index] <= i_wdata;
    end
  end

  // Registered read data, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_index];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_line_responder.sv
// LLC-side responder for L1 line refills and write-backs.
// One outstanding transaction, fixed read/write latency.
module l2_line_responder
  import l2_pkg::*;
#(
  parameter int LINE_COUNT     = 1024,
  parameter int BYTES_PER_LINE = 64,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_LATENCY  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  L2_S_R_ADDR,
  input  logic         L2_S_R_ADDR_VALID,
  output logic [511:0] L2_S_R_DATA,
  output logic         L2_S_R_DATA_VALID,
  input  logic         L2_S_W_VALID,
  input  logic [63:0]  L2_S_W_ADDR,
  input  logic [511:0] L2_S_W_DATA,
  output logic         L2_S_W_READY,
  output logic         L2_S_W_COMPLETE
);

  localparam int INDEX_SIZE  = $clog2(LINE_COUNT);
  localparam int OFFSET_SIZE = $clog2(BYTES_PER_LINE);
  localparam int MAX_LAT     = (READ_LATENCY > WRITE_LATENCY) ?
                               READ_LATENCY : WRITE_LATENCY;
  localparam int CW          = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] RL_M1 = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WL_M1 = CW'(WRITE_LATENCY - 1);
  localparam logic          RL_ONE = (READ_LATENCY == 1);

  responder_state_t        r_state;
  responder_state_t        w_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    r_armed;
  logic                    w_armed;
  logic [INDEX_SIZE-1:0]   r_idx;
  line_t                   r_wdata;

  logic [INDEX_SIZE-1:0]   w_r_idx;
  logic [INDEX_SIZE-1:0]   w_w_idx;
  logic [INDEX_SIZE-1:0]   w_st_idx;
  logic                    w_r_elig;
  logic                    w_w_elig;
  logic                    w_acc_r;
  logic                    w_acc_w;
  logic                    w_rd_done;
  logic                    w_wr_done;
  logic                    w_re;
  line_t                   w_rdata;

  assign w_r_idx = INDEX_SIZE'(
    line_index(L2_S_R_ADDR, OFFSET_SIZE, INDEX_SIZE));
  assign w_w_idx = INDEX_SIZE'(
    line_index(L2_S_W_ADDR, OFFSET_SIZE, INDEX_SIZE));

  assign w_r_elig = L2_S_R_ADDR_VALID && r_armed;
  assign w_w_elig = L2_S_W_VALID && w_armed;

  // Next state, counter, accept decisions and store access.
  // The store read is issued one cycle ahead of the pulse so
  // registered data lines up with DATA_VALID.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_acc_w   = 1'b0;
    w_acc_r   = 1'b0;
    w_rd_done = 1'b0;
    w_wr_done = 1'b0;
    w_re      = 1'b0;
    w_st_idx  = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_w_elig) begin
          w_acc_w   = 1'b1;
          w_next    = WRITE_WAIT;
          w_cnt_nxt = WL_M1;
        end else if (w_r_elig) begin
          w_acc_r   = 1'b1;
          w_next    = READ_WAIT;
          w_cnt_nxt = RL_M1;
          w_re      = RL_ONE;
          w_st_idx  = w_r_idx;
        end
      end
      READ_WAIT: begin
        if (r_cnt == '0) begin
          w_rd_done = 1'b1;
          w_next    = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          w_re      = (r_cnt == CW'(1));
        end
      end
      WRITE_WAIT: begin
        if (r_cnt == '0) begin
          w_wr_done = 1'b1;
          w_next    = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, counter and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_acc_w) begin
        r_idx   <= w_w_idx;
        r_wdata <= L2_S_W_DATA;
      end else if (w_acc_r) begin
        r_idx <= w_r_idx;
      end
    end
  end

  // Arming: a held VALID after its pulse is not re-accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b1;
      w_armed <= 1'b1;
    end else begin
      if (!L2_S_R_ADDR_VALID) begin
        r_armed <= 1'b1;
      end else if (w_rd_done) begin
        r_armed <= 1'b0;
      end
      if (!L2_S_W_VALID) begin
        w_armed <= 1'b1;
      end else if (w_wr_done) begin
        w_armed <= 1'b0;
      end
    end
  end

  l2_line_store #(
    .LINE_COUNT (LINE_COUNT),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_done && !reset),
    .i_re    (w_re && !reset),
    .i_index (w_st_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign L2_S_R_DATA       = w_rdata;
  assign L2_S_R_DATA_VALID = w_rd_done;
  assign L2_S_W_READY      = w_acc_w;
  assign L2_S_W_COMPLETE   = w_wr_done;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder.
// Default latencies plus a 1/7 latency instance.
module tb_l2_line_responder;
  import l2_pkg::*;

  logic         clk;
  logic         reset;

  logic [63:0]  R_ADDR;
  logic         R_VALID;
  logic [511:0] R_DATA;
  logic         DV;
  logic         W_VALID;
  logic [63:0]  W_ADDR;
  logic [511:0] W_DATA;
  logic         READY;
  logic         COMPLETE;

  logic [63:0]  b_R_ADDR;
  logic         b_R_VALID;
  logic [511:0] b_R_DATA;
  logic         b_DV;
  logic         b_W_VALID;
  logic [63:0]  b_W_ADDR;
  logic [511:0] b_W_DATA;
  logic         b_READY;
  logic         b_COMPLETE;

  int checks = 0;
  int errors = 0;

  localparam line_t PA = {8{64'hDEADBEEF_CAFEF00D}};
  localparam line_t PB = {16{32'h0123_4567}};
  localparam line_t PC = {8{64'h1111_2222_3333_4444}};
  localparam line_t PP = {8{64'hA5A5_0000_FFFF_1234}};
  localparam line_t PD = {8{64'h0F0F_F0F0_7777_8888}};

  l2_line_responder dut (
    .clk               (clk),
    .reset             (reset),
    .L2_S_R_ADDR       (R_ADDR),
    .L2_S_R_ADDR_VALID (R_VALID),
    .L2_S_R_DATA       (R_DATA),
    .L2_S_R_DATA_VALID (DV),
    .L2_S_W_VALID      (W_VALID),
    .L2_S_W_ADDR       (W_ADDR),
    .L2_S_W_DATA       (W_DATA),
    .L2_S_W_READY      (READY),
    .L2_S_W_COMPLETE   (COMPLETE)
  );

  l2_line_responder #(
    .READ_LATENCY  (1),
    .WRITE_LATENCY (7)
  ) dut2 (
    .clk               (clk),
    .reset             (reset),
    .L2_S_R_ADDR       (b_R_ADDR),
    .L2_S_R_ADDR_VALID (b_R_VALID),
    .L2_S_R_DATA       (b_R_DATA),
    .L2_S_R_DATA_VALID (b_DV),
    .L2_S_W_VALID      (b_W_VALID),
    .L2_S_W_ADDR       (b_W_ADDR),
    .L2_S_W_DATA       (b_W_DATA),
    .L2_S_W_READY      (b_READY),
    .L2_S_W_COMPLETE   (b_COMPLETE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkd(input string tag, input line_t o, input line_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Write with VALID held one cycle past COMPLETE, then dropped.
  task automatic do_write(input logic [63:0] a, input line_t d,
                          input string tag);
    W_ADDR  = a;
    W_DATA  = d;
    W_VALID = 1'b1;
    #1;
    chk1({tag, "_rdy"}, READY, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      W_DATA = ~d;
      W_ADDR = a + 64'h40;
      chk1($sformatf("%s_cmp%0d", tag, k), COMPLETE, k == 4);
    end
    nxt();
    chk1({tag, "_stale_rdy"}, READY, 1'b0);
    chk1({tag, "_stale_cmp"}, COMPLETE, 1'b0);
    W_VALID = 1'b0;
    nxt();
  endtask

  task automatic do_read(input logic [63:0] a, input line_t e,
                         input string tag);
    R_ADDR  = a;
    R_VALID = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      chk1($sformatf("%s_dv%0d", tag, k), DV, k == 4);
    end
    chkd({tag, "_data"}, R_DATA, e);
    R_VALID = 1'b0;
    nxt();
    chk1({tag, "_dv_after"}, DV, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    R_ADDR    = '0;
    R_VALID   = 1'b0;
    W_VALID   = 1'b0;
    W_ADDR    = '0;
    W_DATA    = '0;
    b_R_ADDR  = '0;
    b_R_VALID = 1'b0;
    b_W_VALID = 1'b0;
    b_W_ADDR  = '0;
    b_W_DATA  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chkd("rst_rdata", R_DATA, '0);
    chk1("rst_dv", DV, 1'b0);
    chk1("rst_rdy", READY, 1'b0);
    chk1("rst_cmp", COMPLETE, 1'b0);
    chkd("rst_rdata2", b_R_DATA, '0);
    checks++;
    assert (dut.r_state === IDLE) else begin
      errors++;
      $error("FAIL rst_state observed=%0d expected=%0d",
             dut.r_state, IDLE);
    end
    nxt();

    do_write(64'h1040, PA, "w1");
    do_read(64'h1040, PA, "r1");

    do_write(64'h1000, PB, "w2");
    do_read(64'h103F, PB, "r_off");
    do_read(64'h11000, PB, "r_alias");
    do_read(64'h1040, PA, "r_other");

    do_write(64'h1000, PC, "w3");
    do_write(64'h1000, PD, "w_rearm");
    do_read(64'h1000, PD, "r_rearm");

    W_ADDR  = 64'h2000;
    W_DATA  = PP;
    W_VALID = 1'b1;
    R_ADDR  = 64'h2000;
    R_VALID = 1'b1;
    #1;
    chk1("sim_rdy", READY, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      nxt();
      chk1($sformatf("sim_cmp%0d", k), COMPLETE, k == 4);
      chk1($sformatf("sim_dv%0d", k), DV, k == 9);
      if (k == 5) begin
        chk1("sim_stale_rdy", READY, 1'b0);
        W_VALID = 1'b0;
      end
    end
    chkd("sim_data", R_DATA, PP);
    R_VALID = 1'b0;
    nxt();

    R_ADDR  = 64'h1040;
    R_VALID = 1'b1;
    nxt();
    nxt();
    reset   = 1'b1;
    R_VALID = 1'b0;
    nxt();
    chk1("mid_rst_dv", DV, 1'b0);
    chkd("mid_rst_rdata", R_DATA, '0);
    checks++;
    assert (dut.r_state === IDLE) else begin
      errors++;
      $error("FAIL mid_rst_state observed=%0d expected=%0d",
             dut.r_state, IDLE);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk1($sformatf("mid_rst_quiet%0d", k), DV, 1'b0);
    end
    do_read(64'h1040, PA, "r_post_rst");

    b_W_ADDR  = 64'h40;
    b_W_DATA  = PC;
    b_W_VALID = 1'b1;
    #1;
    chk1("l7_rdy", b_READY, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      nxt();
      chk1($sformatf("l7_cmp%0d", k), b_COMPLETE, k == 7);
    end
    nxt();
    chk1("l7_stale_cmp", b_COMPLETE, 1'b0);
    b_W_VALID = 1'b0;
    nxt();
    b_R_ADDR  = 64'h40;
    b_R_VALID = 1'b1;
    #1;
    chk1("l1_dv0", b_DV, 1'b0);
    nxt();
    chk1("l1_dv1", b_DV, 1'b1);
    chkd("l1_data", b_R_DATA, PC);
    b_R_VALID = 1'b0;
    nxt();
    chk1("l1_dv2", b_DV, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
